// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package cu_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_B   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    // Immediate format selected purely from the opcode.
    function automatic logic [SEL_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_B:    return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_deco.sv
// ALU operation decoder: ALUOp plus instruction fields to ALUControl.
module mc_alu_deco
    import cu_pkg::*;
(
    input  logic [SEL_W-1:0]  alu_op,
    input  logic [2:0]        funct3,
    input  logic              op5,
    input  logic              funct7_5,
    output logic [ALUC_W-1:0] alu_control
);

    // Fixed add/sub for address and compare, funct3 decode otherwise.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control FSM sequencing the shared ALU and memory of the RV32I core.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     op,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [SEL_W-1:0]    ResultSrc,
    output logic [SEL_W-1:0]    ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [ALUC_W-1:0]   ALUControl,
    output logic [SEL_W-1:0]    ImmSrc,
    output logic                RegWrite,
    output logic                illegal,
    output logic [STATE_W-1:0]  state_dbg
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               illegal_nxt;
    logic [SEL_W-1:0]   alu_op;
    logic               mem_rdy;

    assign mem_rdy   = USE_MEM_READY ? mem_ready : 1'b1;
    assign state_dbg = state;
    assign ImmSrc    = imm_src_of(op);

    // State and illegal-op flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            illegal <= illegal_nxt;
        end
    end

    // Next-state and per-state control decode; unknown encodings give all zeros.
    always_comb begin
        state_nxt   = FETCH;
        illegal_nxt = 1'b0;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        alu_op      = ALUOP_ADD;
        case (state)
            FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                // Writes held off during reset so reset looks like a stalled fetch.
                IRWrite   = mem_rdy & rst_n;
                PCWrite   = mem_rdy & rst_n;
                state_nxt = mem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_R:         state_nxt = EXECR;
                    OP_I:         state_nxt = EXECI;
                    OP_B:         state_nxt = BRANCH;
                    OP_JAL:       state_nxt = JAL;
                    default: begin
                        state_nxt   = FETCH;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                state_nxt = mem_rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                state_nxt = mem_rdy ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_nxt = ALUWB;
            end
            EXECI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                // funct3[0] distinguishes bne from beq.
                PCWrite   = zero ^ funct3[0];
                state_nxt = FETCH;
            end
            JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
                state_nxt = ALUWB;
            end
            default: state_nxt = FETCH;
        endcase
    end

    mc_alu_deco u_alu_deco (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7_5    (funct7_5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_cu.sv
// Randomized bench for multicycle_cu against a per-instruction cycle-trace model.
module tb_multicycle_cu;
    import cu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;
    logic [15:0] dut_ctl;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
        logic        mr;
        logic        z;
    } rec_t;

    rec_t       trace[$];
    logic [1:0] cur_imm;
    logic       ill_pending = 1'b0;

    always #5 clk = ~clk;

    multicycle_cu #(.USE_MEM_READY(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    assign dut_ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                      ALUSrcB, ALUControl, ImmSrc, RegWrite};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // R/I ALU function from funct3; sub only for R-type with funct7[5] set.
    function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f75) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] pk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [2:0] alu, input logic rw);
        return {pcw, adr, mw, irw, rs, a, b, alu, cur_imm, rw};
    endfunction

    function automatic void push(input logic [3:0] st, input logic [15:0] ctl,
                                 input logic mr, input logic z);
        rec_t r;
        r.st = st; r.ctl = ctl; r.ill = 1'b0; r.mr = mr; r.z = z;
        trace.push_back(r);
    endfunction

    // Expected cycle-by-cycle trace of one instruction; zsel 2 = random zero flag.
    function automatic void build(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                                  input int wf, input int wm, input int zsel);
        logic z;
        trace.delete();
        cur_imm = exp_imm(o);
        for (int i = 0; i < wf; i++) push(FETCH, pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,0), 1'b0, rnd());
        push(FETCH,  pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,0), 1'b1, rnd());
        push(DECODE, pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,0), rnd(), rnd());
        case (o)
            7'b0000011: begin
                push(MEMADR, pk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0), rnd(), rnd());
                for (int i = 0; i < wm; i++) push(MEMREAD, pk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0), 1'b0, rnd());
                push(MEMREAD, pk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0), 1'b1, rnd());
                push(MEMWB,   pk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,1), rnd(), rnd());
            end
            7'b0100011: begin
                push(MEMADR, pk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0), rnd(), rnd());
                for (int i = 0; i < wm; i++) push(MEMWRITE, pk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0), 1'b0, rnd());
                push(MEMWRITE, pk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0), 1'b1, rnd());
            end
            7'b0110011: begin
                push(EXECR, pk(0,0,0,0,2'b00,2'b10,2'b00,exp_alu(o,f3,f75),0), rnd(), rnd());
                push(ALUWB, pk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1), rnd(), rnd());
            end
            7'b0010011: begin
                push(EXECI, pk(0,0,0,0,2'b00,2'b10,2'b01,exp_alu(o,f3,f75),0), rnd(), rnd());
                push(ALUWB, pk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1), rnd(), rnd());
            end
            7'b1100011: begin
                z = (zsel == 2) ? rnd() : 1'(zsel);
                push(BRANCH, pk(z ^ f3[0],0,0,0,2'b00,2'b10,2'b00,3'b001,0), rnd(), z);
            end
            7'b1101111: begin
                push(JAL,   pk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,0), rnd(), rnd());
                push(ALUWB, pk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1), rnd(), rnd());
            end
            default: ;
        endcase
    endfunction

    task automatic step(input string name, input rec_t e);
        mem_ready = e.mr;
        zero      = e.z;
        @(negedge clk);
        check({name, ".state"},   32'(state_dbg), 32'(e.st));
        check({name, ".ctl"},     32'(dut_ctl),   32'(e.ctl));
        check({name, ".illegal"}, 32'(illegal),   32'(e.ill));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f75, input int wf, input int wm, input int zsel);
        op = o; funct3 = f3; funct7_5 = f75;
        build(o, f3, f75, wf, wm, zsel);
        trace[0].ill = ill_pending;
        ill_pending  = !is_legal(o);
        for (int i = 0; i < trace.size(); i++) step(name, trace[i]);
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] o;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1110011};

        // Power-up reset with mem_ready high: fetch must still be stalled.
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        op = 7'b0000011; funct3 = 3'b000; funct7_5 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        cur_imm = 2'b00;
        check("reset.state",   32'(state_dbg), 32'(FETCH));
        check("reset.ctl",     32'(dut_ctl),   32'(pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,0)));
        check("reset.illegal", 32'(illegal),   32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // sw stalled in MEMWRITE, then reset for two cycles.
        op = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
        build(7'b0100011, 3'b010, 1'b0, 0, 5, 2);
        for (int i = 0; i < 4; i++) step("sw_rst", trace[i]);
        rst_n = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_mid.state",    32'(state_dbg), 32'(FETCH));
            check("rst_mid.memwrite", 32'(MemWrite),  32'h0);
            check("rst_mid.ctl",      32'(dut_ctl),   32'(pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,0)));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed instructions.
        run_instr("add",   7'b0110011, 3'b000, 1'b0, 0, 0, 2);
        run_instr("sub",   7'b0110011, 3'b000, 1'b1, 0, 0, 2);
        run_instr("addi",  7'b0010011, 3'b000, 1'b1, 0, 0, 2);
        run_instr("lw_w3", 7'b0000011, 3'b010, 1'b0, 0, 3, 2);
        run_instr("beq",   7'b1100011, 3'b000, 1'b0, 0, 0, 1);
        run_instr("bne",   7'b1100011, 3'b001, 1'b0, 0, 0, 1);
        run_instr("ecall", 7'b1110011, 3'b000, 1'b0, 0, 0, 2);
        run_instr("jal",   7'b1101111, 3'b000, 1'b0, 0, 0, 2);
        run_instr("sw_w2", 7'b0100011, 3'b010, 1'b0, 1, 2, 2);

        // Random instruction mix with random wait states.
        for (int n = 0; n < 300; n++) begin
            o = ops[$urandom_range(0, 6)];
            if (!is_legal(o)) begin
                do o = 7'($urandom_range(0, 127)); while (is_legal(o));
            end
            run_instr("rand", o, 3'($urandom_range(0, 7)), rnd(),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2);
        end
        // Final cycle observes any illegal pulse left by the last instruction.
        op = 7'b0110011;
        cur_imm = 2'b00;
        begin
            rec_t r;
            r.st = FETCH; r.ctl = pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,0);
            r.ill = ill_pending; r.mr = 1'b0; r.z = 1'b0;
            step("tail", r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
